// File: rtl/nanorv32_ram_initiator_if.sv
// nanorv32_ram_initiator_if
// Bundles the LSU request/response channel and the single-port byte-write
// RAM port driven by nanorv32_ram_initiator.
//   master : the initiator (accepts req_*, produces rsp_* and ram_we/addr/din)
//   slave  : the environment (LSU issuing requests, RAM returning ram_dout)
// Parameter ADDR_WIDTH: RAM word-address width; byte address is ADDR_WIDTH+2.
interface nanorv32_ram_initiator_if #(
  parameter int ADDR_WIDTH = 12
);
  logic                  req_valid;
  logic                  req_ready;
  logic [ADDR_WIDTH+1:0] req_addr;
  logic                  req_write;
  logic [1:0]            req_size;
  logic                  req_unsigned;
  logic [31:0]           req_wdata;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [31:0]           rsp_rdata;
  logic                  rsp_err;
  logic [3:0]            ram_we;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [31:0]           ram_din;
  logic [31:0]           ram_dout;

  modport master (
    input  req_valid, req_addr, req_write, req_size, req_unsigned, req_wdata,
    input  rsp_ready, ram_dout,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, ram_we, ram_addr, ram_din
  );

  modport slave (
    output req_valid, req_addr, req_write, req_size, req_unsigned, req_wdata,
    output rsp_ready, ram_dout,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, ram_we, ram_addr, ram_din
  );
endinterface

// File: rtl/nanorv32_ram_initiator.sv
// nanorv32_ram_initiator
// Drives a single-port, byte-write 32-bit RAM on behalf of the LSU. One
// request outstanding at a time; byte/half/word stores are lane-replicated
// with byte enables, loads are lane-extracted and sign/zero extended,
// misaligned or size=11 requests return rsp_err without touching the RAM.
// Ports:
//   clk    : clock shared with the RAM
//   rst_n  : asynchronous active-low reset
//   bus    : nanorv32_ram_initiator_if.master (req_*, rsp_*, ram_*)
// Build option:
//   NANORV32_RAM_DOUT_REG_EN : RAM has an extra output register; loads wait
//                              one more cycle (RDWAIT2) before capturing dout.
module nanorv32_ram_initiator #(
  parameter int ADDR_WIDTH = 12
) (
  input  logic clk,
  input  logic rst_n,
  nanorv32_ram_initiator_if.master bus
);

`ifdef NANORV32_RAM_DOUT_REG_EN
  typedef enum logic [2:0] {S_IDLE, S_ACCESS, S_RDWAIT, S_RDWAIT2, S_RESP} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_ACCESS, S_RDWAIT, S_RESP} state_t;
`endif

  state_t                r_state, w_state;
  logic [1:0]            r_off, w_off;
  logic [1:0]            r_size, w_size;
  logic                  r_uns, w_uns;
  logic                  r_write, w_write;
  logic                  r_bad, w_bad;
  logic [3:0]            r_we, w_we;
  logic [ADDR_WIDTH-1:0] r_addr, w_addr;
  logic [31:0]           r_din, w_din;
  logic                  r_rsp_valid, w_rsp_valid;
  logic [31:0]           r_rdata, w_rdata;
  logic                  r_err, w_err;

  logic                  w_illegal;
  logic [3:0]            w_lane_we;
  logic [31:0]           w_lane_din;
  logic [31:0]           w_fmt;

  function automatic logic [31:0] fmt_load(input logic [31:0] d, input logic [1:0] off,
                                           input logic [1:0] sz, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    b = d[{off, 3'b000} +: 8];
    h = d[{off[1], 4'b0000} +: 16];
    case (sz)
      2'd0:    fmt_load = {{24{b[7] & ~uns}}, b};
      2'd1:    fmt_load = {{16{h[15] & ~uns}}, h};
      default: fmt_load = d;
    endcase
  endfunction

  assign w_illegal = (bus.req_size == 2'd3) ||
                     (bus.req_size == 2'd1 && bus.req_addr[0]) ||
                     (bus.req_size == 2'd2 && bus.req_addr[1:0] != 2'd0);

  always_comb begin
    case (bus.req_size)
      2'd0:    begin w_lane_we = 4'b0001 << bus.req_addr[1:0]; w_lane_din = {4{bus.req_wdata[7:0]}};  end
      2'd1:    begin w_lane_we = 4'b0011 << bus.req_addr[1:0]; w_lane_din = {2{bus.req_wdata[15:0]}}; end
      default: begin w_lane_we = 4'b1111;                     w_lane_din = bus.req_wdata;            end
    endcase
  end

  assign w_fmt = fmt_load(bus.ram_dout, r_off, r_size, r_uns);

  always_comb begin
    w_state     = r_state;
    w_off       = r_off;
    w_size      = r_size;
    w_uns       = r_uns;
    w_write     = r_write;
    w_bad       = r_bad;
    w_we        = r_we;
    w_addr      = r_addr;
    w_din       = r_din;
    w_rsp_valid = r_rsp_valid;
    w_rdata     = r_rdata;
    w_err       = r_err;
    case (r_state)
      S_IDLE: if (bus.req_valid) begin
        w_off   = bus.req_addr[1:0];
        w_size  = bus.req_size;
        w_uns   = bus.req_unsigned;
        w_write = bus.req_write;
        w_bad   = w_illegal;
        // Errors also pass through ACCESS (with ram_we held 0) so every
        // non-load response lands exactly one clock after accept.
        w_state = S_ACCESS;
        if (!w_illegal) begin
          w_addr = bus.req_addr[ADDR_WIDTH+1:2];
          if (bus.req_write) begin
            w_we  = w_lane_we;
            w_din = w_lane_din;
          end
        end
      end
      S_ACCESS: begin
        w_we = 4'b0000;  // RAM samples the write at this edge; one-shot
        if (r_write || r_bad) begin
          w_state     = S_RESP;
          w_rsp_valid = 1'b1;
          w_err       = r_bad;
          w_rdata     = 32'd0;
        end else begin
          w_state = S_RDWAIT;
        end
      end
`ifdef NANORV32_RAM_DOUT_REG_EN
      S_RDWAIT:  w_state = S_RDWAIT2;
      S_RDWAIT2: begin
`else
      S_RDWAIT: begin
`endif
        w_rdata     = w_fmt;
        w_rsp_valid = 1'b1;
        w_state     = S_RESP;
      end
      S_RESP: if (bus.rsp_ready) begin
        w_rsp_valid = 1'b0;
        w_err       = 1'b0;
        w_state     = S_IDLE;
      end
      default: w_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_off       <= 2'd0;
      r_size      <= 2'd0;
      r_uns       <= 1'b0;
      r_write     <= 1'b0;
      r_bad       <= 1'b0;
      r_we        <= 4'b0000;
      r_addr      <= '0;
      r_din       <= 32'd0;
      r_rsp_valid <= 1'b0;
      r_rdata     <= 32'd0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_off       <= w_off;
      r_size      <= w_size;
      r_uns       <= w_uns;
      r_write     <= w_write;
      r_bad       <= w_bad;
      r_we        <= w_we;
      r_addr      <= w_addr;
      r_din       <= w_din;
      r_rsp_valid <= w_rsp_valid;
      r_rdata     <= w_rdata;
      r_err       <= w_err;
    end
  end

  assign bus.req_ready = (r_state == S_IDLE);
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_rdata = r_rdata;
  assign bus.rsp_err   = r_err;
  assign bus.ram_we    = r_we;
  assign bus.ram_addr  = r_addr;
  assign bus.ram_din   = r_din;

endmodule

// File: tb/tb_nanorv32_ram_initiator.sv
// Bench for nanorv32_ram_initiator: a behavioural RAM (1 or 2 cycle read
// latency) plus a byte-array reference memory; directed cases followed by
// randomized requests with random backpressure and ignored-input noise.
module tb_nanorv32_ram_initiator;
  localparam int AW = 12;
`ifdef NANORV32_RAM_DOUT_REG_EN
  localparam int LD_LAT = 3;
`else
  localparam int LD_LAT = 2;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  nanorv32_ram_initiator_if #(.ADDR_WIDTH(AW)) bus();
  nanorv32_ram_initiator #(.ADDR_WIDTH(AW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // RAM macro model: synchronous byte-write, registered read.
  logic        ram_init = 1'b1;
  logic [31:0] mem [0:(1<<AW)-1];
  logic [31:0] dq1, dq2;
  always @(posedge clk) begin
    if (ram_init) begin
      for (int i = 0; i < (1<<AW); i++) mem[i] <= 32'd0;
    end else begin
      for (int b = 0; b < 4; b++)
        if (bus.ram_we[b]) mem[bus.ram_addr][8*b +: 8] <= bus.ram_din[8*b +: 8];
    end
    dq1 <= mem[bus.ram_addr];
    dq2 <= dq1;
  end
`ifdef NANORV32_RAM_DOUT_REG_EN
  assign bus.ram_dout = dq2;
`else
  assign bus.ram_dout = dq1;
`endif

  logic [7:0] ref_mem [0:(4<<AW)-1];

  function automatic logic [31:0] ref_word(input int wa);
    return {ref_mem[4*wa+3], ref_mem[4*wa+2], ref_mem[4*wa+1], ref_mem[4*wa]};
  endfunction

  task automatic drive_junk();
    bus.req_valid    = 1'b1;
    bus.req_addr     = (AW+2)'($urandom);
    bus.req_write    = 1'($urandom_range(0, 1));
    bus.req_size     = 2'($urandom_range(0, 3));
    bus.req_unsigned = 1'($urandom_range(0, 1));
    bus.req_wdata    = $urandom;
    bus.rsp_ready    = 1'($urandom_range(0, 1));
  endtask

  // Called at a negedge with the DUT idle. Issues one request, checks
  // latency, RAM port activity, response and backpressure behaviour.
  task automatic do_req(input logic [AW+1:0] a, input logic w, input logic [1:0] sz,
                        input logic u, input logic [31:0] wd, input int hold,
                        output logic [31:0] rd);
    logic        bad;
    int          nb, lat, we_cyc;
    logic [31:0] exp_rd, exp_din, s_din;
    logic [3:0]  exp_we, s_we;
    logic [AW-1:0] s_addr;
    bit          got;
    bad = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0);
    nb  = 1 << sz;
    exp_rd = 32'd0;
    if (!bad && !w) begin
      for (int i = 0; i < nb; i++) exp_rd |= {24'd0, ref_mem[int'(a) + i]} << (8*i);
      if (!u && nb < 4 && ref_mem[int'(a) + nb - 1][7]) exp_rd |= 32'hFFFFFFFF << (8*nb);
    end
    exp_we = 4'd0;
    for (int i = 0; i < nb && i < 4; i++) exp_we[int'(a[1:0]) + i] = 1'b1;
    exp_din = (sz == 2'd0) ? {4{wd[7:0]}} : (sz == 2'd1) ? {2{wd[15:0]}} : wd;

    chk("req_ready_idle", bus.req_ready, 1);
    bus.req_valid = 1'b1; bus.req_addr = a; bus.req_write = w;
    bus.req_size = sz; bus.req_unsigned = u; bus.req_wdata = wd; bus.rsp_ready = 1'b0;
    @(posedge clk); @(negedge clk);
    got = 0; lat = 0; we_cyc = 0; s_we = '0; s_din = '0; s_addr = '0;
    for (int c = 1; c <= 10 && !got; c++) begin
      if (bus.ram_we != 4'd0) begin
        we_cyc++; s_we = bus.ram_we; s_din = bus.ram_din; s_addr = bus.ram_addr;
      end
      if (bus.rsp_valid) begin
        got = 1; lat = c - 1;
      end else begin
        drive_junk();
        @(posedge clk); @(negedge clk);
      end
    end
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b0;
    if (!got) begin
      chk("rsp_timeout", 0, 1);
      rd = 32'hx;
      return;
    end
    chk("latency", lat, (bad || w) ? 1 : LD_LAT);
    chk("rsp_err", bus.rsp_err, bad);
    chk("rsp_rdata", bus.rsp_rdata, exp_rd);
    chk("we_cycles", we_cyc, (!bad && w) ? 1 : 0);
    if (!bad && w) begin
      chk("ram_we", s_we, exp_we);
      chk("ram_addr", s_addr, a[AW+1:2]);
      chk("ram_din", s_din, exp_din);
      for (int i = 0; i < nb; i++) ref_mem[int'(a) + i] = wd[8*i +: 8];
    end
    rd = bus.rsp_rdata;
    for (int h = 0; h < hold; h++) begin
      bus.req_valid = 1'b1; bus.req_addr = (AW+2)'($urandom);
      @(posedge clk); @(negedge clk);
      chk("hold_valid", bus.rsp_valid, 1);
      chk("hold_rdata", bus.rsp_rdata, exp_rd);
      chk("hold_req_ready", bus.req_ready, 0);
    end
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    bus.rsp_ready = 1'b0;
    chk("rsp_cleared", bus.rsp_valid, 0);
    chk("err_cleared", bus.rsp_err, 0);
    chk("ready_after", bus.req_ready, 1);
  endtask

  initial begin
    logic [31:0] rd;
    bus.req_valid = 1'b0; bus.req_addr = '0; bus.req_write = 1'b0; bus.req_size = 2'd0;
    bus.req_unsigned = 1'b0; bus.req_wdata = 32'd0; bus.rsp_ready = 1'b0;
    for (int i = 0; i < (4<<AW); i++) ref_mem[i] = 8'd0;
    repeat (3) @(negedge clk);
    ram_init = 1'b0;
    chk("rst_ram_we", bus.ram_we, 0);
    chk("rst_ram_addr", bus.ram_addr, 0);
    chk("rst_ram_din", bus.ram_din, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_rsp_rdata", bus.rsp_rdata, 0);
    chk("rst_rsp_err", bus.rsp_err, 0);
    rst_n = 1'b1;
    @(negedge clk);

    do_req(14'h010, 1, 2'd2, 0, 32'hDEADBEEF, 0, rd);
    chk("st_word_rdata", rd, 32'd0);
    do_req(14'h013, 1, 2'd0, 0, 32'h000000A5, 0, rd);
    do_req(14'h010, 0, 2'd2, 0, 32'd0, 0, rd);
    chk("ld_merge", rd, 32'hA5ADBEEF);

    do_req(14'h020, 1, 2'd2, 0, 32'h80FF7F01, 0, rd);
    do_req(14'h021, 0, 2'd0, 0, 32'd0, 0, rd); chk("ld_b_s_21", rd, 32'h0000007F);
    do_req(14'h022, 0, 2'd0, 0, 32'd0, 0, rd); chk("ld_b_s_22", rd, 32'hFFFFFFFF);
    do_req(14'h022, 0, 2'd1, 1, 32'd0, 0, rd); chk("ld_h_u_22", rd, 32'h000080FF);
    do_req(14'h022, 0, 2'd1, 0, 32'd0, 0, rd); chk("ld_h_s_22", rd, 32'hFFFF80FF);

    do_req(14'h011, 1, 2'd1, 0, 32'h1234, 0, rd);
    do_req(14'h00E, 0, 2'd2, 0, 32'd0, 0, rd);
    do_req(14'h000, 0, 2'd3, 0, 32'd0, 0, rd);

    do_req(14'h020, 0, 2'd2, 0, 32'd0, 5, rd);
    chk("bp_rdata", rd, 32'h80FF7F01);

    // Reset between accept and the RAM sampling edge drops the write.
    bus.req_valid = 1'b1; bus.req_addr = 14'h030; bus.req_write = 1'b1;
    bus.req_size = 2'd2; bus.req_wdata = 32'h12345678; bus.req_unsigned = 1'b0;
    @(posedge clk);
    #2;
    bus.req_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("abort_we", bus.ram_we, 0);
    chk("abort_rsp", bus.rsp_valid, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_ready", bus.req_ready, 1);
    chk("abort_rsp_after", bus.rsp_valid, 0);
    chk("abort_mem", mem[12], 32'd0);
    do_req(14'h030, 0, 2'd2, 0, 32'd0, 0, rd);

    for (int n = 0; n < 300; n++) begin
      do_req((AW+2)'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
             2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), $urandom,
             $urandom_range(0, 3), rd);
    end

    for (int i = 0; i < 64; i++) chk("mem_sweep", mem[i], ref_word(i));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
